// File: rtl/memory_burst_if.sv
// Request/response bundle between a memory client and memory_burst.
// The master drives requests and write data; the slave returns busy, read data and errors.
interface memory_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      enable;
    logic                      rw;
    logic [ADDR_WIDTH-1:0]     address;
    logic [1:0]                access_size;
    logic [DATA_WIDTH/8-1:0]   byte_en;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      busy;
    logic                      rd_valid;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      err;

    modport master (
        output enable, rw, address, access_size, byte_en, data_in,
        input  busy, rd_valid, data_out, err
    );

    modport slave (
        input  enable, rw, address, access_size, byte_en, data_in,
        output busy, rd_valid, data_out, err
    );
endinterface

// File: rtl/memory_burst.sv
// Byte-addressed, word-organised burst memory shared by instruction fetch and load/store.
// state | meaning: IDLE = accepting requests, single beats done here | READ = read burst beats 1..N-1 | WRITE = write burst beats 1..N-1
module memory_burst #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8002_0000
) (
    input  logic           clock,
    input  logic           reset_n,
    memory_burst_if.slave  bus
);
    localparam int W      = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(W);
    localparam int WORDS  = DEPTH_BYTES / W;
    localparam int WIDX_W = $clog2(WORDS);
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  r_state;
    logic [3:0]              r_left;
    logic [WIDX_W-1:0]       r_widx;
    logic                    r_busy;
    logic                    r_rd_valid;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [DATA_WIDTH-1:0]   r_mem [WORDS];

    logic [4:0]              w_nbeats;
    logic [ADDR_WIDTH:0]     w_end;
    logic                    w_reject;
    logic                    w_accept;
    logic [WIDX_W-1:0]       w_idx;
    logic                    w_do_rd;
    logic                    w_do_wr;

    always_comb begin
        w_nbeats = 5'd1;
        case (bus.access_size)
            2'b00:   w_nbeats = 5'd1;
            2'b01:   w_nbeats = 5'd4;
            2'b10:   w_nbeats = 5'd8;
            default: w_nbeats = 5'd16;
        endcase
        // One extra bit so a burst running past the top of the address space cannot wrap.
        w_end    = {1'b0, bus.address} + (ADDR_WIDTH+1)'(w_nbeats) * (ADDR_WIDTH+1)'(W);
        w_reject = (bus.address[OFF_W-1:0] != '0) || (bus.address < BASE_ADDR) || (w_end > LIMIT);
        w_accept = (r_state == IDLE) && bus.enable && !w_reject;
        w_idx    = (r_state == IDLE) ? WIDX_W'((bus.address - BASE_ADDR) >> OFF_W) : r_widx;
        w_do_rd  = (w_accept && bus.rw) || (r_state == READ);
        // Gated by reset so an asserted reset stops an in-flight burst from writing.
        w_do_wr  = reset_n && ((w_accept && !bus.rw) || (r_state == WRITE));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_left     <= '0;
            r_widx     <= '0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_err      <= (r_state == IDLE) && bus.enable && w_reject;
            r_rd_valid <= w_do_rd;
            if (w_do_rd)
                r_data_out <= r_mem[w_idx];
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_nbeats != 5'd1)) begin
                        r_state <= bus.rw ? READ : WRITE;
                        r_busy  <= 1'b1;
                        r_left  <= 4'(w_nbeats - 5'd1);
                        r_widx  <= w_idx + 1'b1;
                    end
                end
                default: begin
                    r_widx <= r_widx + 1'b1;
                    r_left <= r_left - 4'd1;
                    if (r_left == 4'd1) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            for (int i = 0; i < W; i++) begin
                if (bus.byte_en[i])
                    r_mem[w_idx][8*i +: 8] <= bus.data_in[8*i +: 8];
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.rd_valid = r_rd_valid;
    assign bus.data_out = r_data_out;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_memory_burst.sv
// Directed bench for memory_burst: single/burst accesses, byte lanes, range errors, reset mid-burst.
module tb_memory_burst;
    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam logic [31:0] DEPTH = 32'h0010_0000;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_bad;

    memory_burst_if bus ();

    memory_burst dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic start(input logic rw_i, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] be, input logic [31:0] d);
        bus.enable      = 1'b1;
        bus.rw          = rw_i;
        bus.address     = a;
        bus.access_size = sz;
        bus.byte_en     = be;
        bus.data_in     = d;
    endtask

    task automatic single_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clock);
        start(1'b0, a, 2'b00, be, d);
        @(negedge clock);
        bus.enable = 1'b0;
        chk("swr_busy", 32'(bus.busy), 0);
        chk("swr_err", 32'(bus.err), 0);
        chk("swr_rdv", 32'(bus.rd_valid), 0);
    endtask

    task automatic single_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clock);
        start(1'b1, a, 2'b00, 4'hF, 32'h0);
        @(negedge clock);
        bus.enable = 1'b0;
        chk({tag, "_rdv"}, 32'(bus.rd_valid), 1);
        chk({tag, "_data"}, bus.data_out, exp);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic burst_write(input logic [31:0] a, input logic [1:0] sz, input int n,
                               input logic [31:0] d0, input logic [31:0] step);
        @(negedge clock);
        start(1'b0, a, sz, 4'hF, d0);
        for (int k = 1; k < n; k++) begin
            @(negedge clock);
            bus.enable  = 1'b0;
            bus.data_in = d0 + 32'(k) * step;
            chk("bwr_busy", 32'(bus.busy), 1);
            chk("bwr_err", 32'(bus.err), 0);
        end
        @(negedge clock);
        bus.enable = 1'b0;
        chk("bwr_done", 32'(bus.busy), 0);
    endtask

    task automatic burst_read(input logic [31:0] a, input logic [1:0] sz, input int n,
                              input logic [31:0] d0, input logic [31:0] step);
        logic [31:0] exp;
        exp = d0;
        @(negedge clock);
        start(1'b1, a, sz, 4'hF, 32'h0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            bus.enable = 1'b0;
            exp = d0 + 32'(k - 1) * step;
            chk("brd_rdv", 32'(bus.rd_valid), 1);
            chk("brd_data", bus.data_out, exp);
            chk("brd_busy", 32'(bus.busy), (k < n) ? 32'd1 : 32'd0);
            chk("brd_err", 32'(bus.err), 0);
        end
        @(negedge clock);
        chk("brd_rdv_off", 32'(bus.rd_valid), 0);
        chk("brd_hold", bus.data_out, exp);
    endtask

    task automatic err_case(input string tag, input logic [31:0] a, input logic [1:0] sz);
        @(negedge clock);
        start(1'b0, a, sz, 4'hF, 32'hBAD0_BAD0);
        @(negedge clock);
        bus.enable = 1'b0;
        chk({tag, "_err"}, 32'(bus.err), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_rdv"}, 32'(bus.rd_valid), 0);
        @(negedge clock);
        chk({tag, "_err_pulse"}, 32'(bus.err), 0);
        chk({tag, "_busy2"}, 32'(bus.busy), 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b0;
        bus.enable = 1'b0;
        bus.rw = 1'b0;
        bus.address = '0;
        bus.access_size = 2'b00;
        bus.byte_en = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rdv", 32'(bus.rd_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_dout", bus.data_out, 0);
        reset_n = 1'b1;

        single_write(BASE, 4'hF, 32'hDEAD_BEEF);
        single_read("srd", BASE, 32'hDEAD_BEEF);

        burst_write(BASE + 32'h10, 2'b01, 4, 32'h11, 32'h11);
        burst_read(BASE + 32'h10, 2'b01, 4, 32'h11, 32'h11);

        single_write(BASE, 4'b0001, 32'h0000_00AA);
        single_read("bytewr", BASE, 32'hDEAD_BEAA);

        single_write(BASE + DEPTH - 32'd32, 4'hF, 32'h1234_5678);
        err_case("misalign", BASE + 32'd2, 2'b00);
        err_case("below", 32'h8001_FFFC, 2'b00);
        err_case("overrun", BASE + DEPTH - 32'd32, 2'b11);
        single_read("keep_base", BASE, 32'hDEAD_BEAA);
        single_read("keep_top", BASE + DEPTH - 32'd32, 32'h1234_5678);

        burst_write(BASE + DEPTH - 32'd64, 2'b11, 16, 32'hC0DE_0000, 32'h1);
        burst_read(BASE + DEPTH - 32'd64, 2'b11, 16, 32'hC0DE_0000, 32'h1);

        // Prefill, then abort an 8-beat write after beat 1.
        burst_write(BASE + 32'h100, 2'b10, 8, 32'h5500_0000, 32'h1);
        @(negedge clock);
        start(1'b0, BASE + 32'h100, 2'b10, 4'hF, 32'hA0);
        @(negedge clock);
        bus.enable  = 1'b0;
        bus.data_in = 32'hA1;
        chk("abort_busy_pre", 32'(bus.busy), 1);
        @(negedge clock);
        bus.data_in = 32'hA2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_rdv", 32'(bus.rd_valid), 0);
        chk("abort_dout", bus.data_out, 0);
        @(negedge clock);
        reset_n = 1'b1;

        @(negedge clock);
        start(1'b1, BASE + 32'h100, 2'b10, 4'hF, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chk("abort_rd_rdv", 32'(bus.rd_valid), 1);
            chk("abort_rd_data", bus.data_out,
                (k <= 2) ? 32'hA0 + 32'(k - 1) : 32'h5500_0000 + 32'(k - 1));
            chk("abort_rd_busy", 32'(bus.busy), (k < 8) ? 32'd1 : 32'd0);
            if (k < 8)
                start(1'b0, BASE, 2'b00, 4'hF, 32'h0000_0000);
            else
                bus.enable = 1'b0;
        end
        @(negedge clock);
        chk("abort_rd_end", 32'(bus.rd_valid), 0);
        chk("abort_no_extra", 32'(bus.busy), 0);
        single_read("ignored_wr", BASE, 32'hDEAD_BEAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/memory_burst.md
Name: memory_burst

Overview:
- Parametrised, byte-addressed, word-organised synchronous main memory for the MIPS core.
- Serves both the instruction-fetch and the load/store path.
- Successor to the single-word memory: configurable width, depth and base address; multi-beat bursts selected by access_size; per-byte write enables; range/alignment error reporting; busy handshake driven by an explicit state machine.

Parameters:
- DATA_WIDTH, 32, bits per word/beat; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_BYTES, 1048576, storage size in bytes; multiple of DATA_WIDTH/8.
- BASE_ADDR, 32'h8002_0000, byte address of the first stored byte.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  request strobe; accepted only when busy=0.
- rw  in  1  1=read, 0=write.
- address  in  ADDR_WIDTH  byte address of beat 0.
- access_size  in  2  burst length: 00=1, 01=4, 10=8, 11=16 beats.
- byte_en  in  DATA_WIDTH/8  write byte mask, MSB lane = lowest byte address (big-endian); ignored on reads.
- data_in  in  DATA_WIDTH  write data, sampled once per write beat.
- busy  out  1  burst in progress; new requests ignored.
- rd_valid  out  1  data_out holds a valid read beat.
- data_out  out  DATA_WIDTH  read data, registered.
- err  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; busy=0, rd_valid=0, err=0, data_out=0; beat counter and address register cleared.
  - Storage contents are not reset.
  - Reset mid-burst abandons the burst immediately; remaining beats are not performed.
- Word size: W = DATA_WIDTH/8 bytes. Word index = (addr - BASE_ADDR)/W. Big-endian byte lanes.
- Burst length: N = {1,4,8,16}[access_size].
- Acceptance edge E0 (enable=1, busy=0 in IDLE):
  - Error check: reject if address[log2(W)-1:0]≠0, address<BASE_ADDR, or address+N*W > BASE_ADDR+DEPTH_BYTES (computed in ADDR_WIDTH+1 bits, so no wrap-around).
  - Rejected request: err=1 for exactly one cycle, no storage access, busy stays 0, rd_valid=0.
- Beat k of an accepted burst occurs at edge Ek (k=0..N-1), one beat per cycle, zero wait states, address incrementing by W.
- Write beat: for each lane i with byte_en[i]=1, write data_in lane i to the word; lanes with byte_en[i]=0 keep old contents. byte_en=0 performs no write. rd_valid stays 0.
- Read beat: at Ek, data_out <= mem[word k] and rd_valid <= 1. Beat k is visible in the cycle after Ek. rd_valid falls at E(N) unless a new read is accepted at that edge.
- FSM states: IDLE, READ, WRITE.
  - IDLE -> READ/WRITE at E0 when N>1; N=1 completes at E0 and stays IDLE.
  - READ/WRITE -> IDLE at E(N-1).
  - busy=1 from after E0 through E(N-1): exactly N-1 cycles. Single-beat accesses never raise busy.
- While busy:
  - enable, rw, address, access_size are ignored.
  - data_in and byte_en are sampled at each write edge.
- A request presented in the cycle after E(N-1) (busy=0) is accepted back-to-back.
- Read-after-write to the same word in consecutive cycles returns the newly written data. The write lands at its edge; the read samples at the following edge.
- data_out holds its last value when rd_valid=0; it is not cleared.

Test Plan:
- Reset, then single write 0xDEADBEEF @0x80020000 (byte_en=1111), then single read -> cycle after read edge: rd_valid=1, data_out=0xDEADBEEF, busy never 1, err=0.
- Write burst access_size=01 @0x80020010 with data 0x11,0x22,0x33,0x44; then read burst of 4 -> busy high 3 cycles for each burst; rd_valid high 4 consecutive cycles with 0x11,0x22,0x33,0x44 in order.
- Read 0x80020000 holding 0xDEADBEEF after a byte write of 0x000000AA with byte_en=0001 -> data_out=0xDEADBEAA.
- Error cases: address 0x80020002; address 0x8001FFFC; access_size=11 @BASE+DEPTH_BYTES-32 -> each gives err=1 for one cycle, busy=0, rd_valid=0, memory unchanged.
- Last-word case: access_size=11 @BASE+DEPTH_BYTES-64 -> accepted, 16 beats, no err.
- Assert reset_n=0 at beat 2 of an 8-beat write -> busy=0 and rd_valid=0 immediately; beats 0-1 retained, beats 2-7 unwritten. A following request is accepted normally; enable pulses during busy produce no extra beats.
